// File: rtl/add_arbiter_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// Optional statistics counter is enabled with ADD_ARBITER_STATS_EN.
package add_arbiter_pkg;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bundle between requesters (master) and the arbiter (slave).
// Requester i owns bits [i*W +: W] of req_a and req_b.
interface add_arbiter_if #(
    parameter int NREQ = add_arbiter_pkg::DEFAULT_NREQ,
    parameter int W    = add_arbiter_pkg::DEFAULT_W
);
    import add_arbiter_pkg::*;

    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [W:0]        rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/add_core.sv
// Shared registered adder: W-bit operands, W+1-bit result one cycle after en.
module add_core
    import add_arbiter_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    logic [W:0] sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= {1'b0, a} + {1'b0, b};
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding one shared adder: IDLE grants, CALC adds, RESP holds result.
// Define ADD_ARBITER_STATS_EN to add the 16-bit op_count output.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    add_arbiter_if.slave      bus,
    output logic              busy
`ifdef ADD_ARBITER_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);

    localparam int ID_W = id_width(NREQ);

    state_t          state_reg, state_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;
    logic [ID_W-1:0] id_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [ID_W-1:0] winner;
    logic            any_valid;
    logic            grant_en;
    logic            calc_en;
    logic            rsp_fire;
    logic [NREQ-1:0] grant;
    logic [W:0]      core_sum;

    logic [ID_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0] cand_valid;

    // Candidate gi is the requester gi places after the pointer, wrapping at NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [ID_W:0] raw_idx;
        assign raw_idx        = {1'b0, ptr_reg} + (ID_W+1)'(gi);
        assign cand_idx[gi]   = (raw_idx >= (ID_W+1)'(NREQ))
                              ? ID_W'(raw_idx - (ID_W+1)'(NREQ))
                              : raw_idx[ID_W-1:0];
        assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
    end

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                winner    = cand_idx[k];
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_en   = 1'b0;
        calc_en    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    grant_en   = 1'b1;
                    ptr_next   = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
                    state_next = CALC;
                end
            end
            CALC: begin
                calc_en    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (grant_en) begin
                id_reg <= winner;
                a_reg  <= bus.req_a[winner*W +: W];
                b_reg  <= bus.req_b[winner*W +: W];
            end
        end
    end

    add_core #(.W(W)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (calc_en),
        .a     (a_reg),
        .b     (b_reg),
        .sum   (core_sum)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = grant_en && (winner == ID_W'(gi));
    end

    // Gate with rst_n so no accept is offered while reset is held.
    assign bus.req_ready = rst_n ? grant : '0;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_sum   = core_sum;
    assign busy          = (state_reg != IDLE);
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

`ifdef ADD_ARBITER_STATS_EN
    logic [15:0] op_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (rsp_fire) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign op_count = op_count_reg;
`else
    logic unused_fire;
    assign unused_fire = rsp_fire;
`endif

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, operand width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester operand accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W].
REQ-008 SHALL have port req_b  input  NREQ*W  operand B, same packing.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  result consumer ready.
REQ-011 SHALL have port rsp_id  output  clog2(NREQ)  index of requester owning result.
REQ-012 SHALL have port rsp_sum  output  W+1  full sum including carry-out.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> RESP -> IDLE.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready for round-robin winner (first valid at or after pointer, wrapping); operands captured same edge; next state CALC.
REQ-016 IDLE with no req_valid SHALL hold IDLE, all req_ready low.
REQ-017 req_ready SHALL be asserted only in IDLE and only for a requester whose req_valid is high.
REQ-018 CALC: shared adder registers sum in exactly one cycle; next state RESP.
REQ-019 RESP: rsp_valid high; rsp_sum and rsp_id SHALL remain stable until rsp_valid && rsp_ready; then IDLE.
REQ-020 Pointer SHALL update to winner+1 modulo NREQ on each grant; wrap NREQ-1 -> 0.
REQ-021 Sum SHALL be unsigned, W+1 bits, no truncation (0xFF+0xFF = 0x1FE for W=8).
REQ-022 Minimum latency grant-to-rsp_valid SHALL be 2 cycles; max throughput one op per 3 cycles.
REQ-023 Requests arriving in CALC/RESP SHALL wait; no request is dropped while its req_valid stays high.

Reset
REQ-024 On rst_n low SHALL asynchronously force: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, busy 0, pointer 0.
REQ-025 Reset mid-operation SHALL discard the in-flight operation with no response.

Configuration
REQ-026 With ADD_ARBITER_STATS_EN defined, SHALL add output op_count (16 bits) incrementing on each rsp handshake, reset 0, wrapping 0xFFFF -> 0x0000.
REQ-027 Without ADD_ARBITER_STATS_EN, op_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 State encoding enum (IDLE, CALC, RESP) and default widths SHALL reside in package add_arbiter_pkg.
REQ-029 Shared datapath SHALL be one sub-module add_core: registered W-bit add, W+1-bit result, one-cycle latency, clk/rst_n.
REQ-030 Round-robin winner selection SHALL be combinational inside add_arbiter.

Verification
REQ-031 Single request: req 2 a=0x12 b=0x34 -> req_ready[2] one cycle, 2 cycles later rsp_valid, rsp_id=2, rsp_sum=0x046.
REQ-032 Overflow: a=0xFF b=0xFF -> rsp_sum=0x1FE.
REQ-033 All four valid continuously from reset -> grant order 0,1,2,3,0; each result matches own operands.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_sum, rsp_id stable, no new req_ready, busy=1.
REQ-035 rst_n low during CALC -> rsp_valid 0 immediately, state IDLE, next grant goes to requester 0.
REQ-036 With ADD_ARBITER_STATS_EN, 3 completed ops -> op_count=3; force 0xFFFF plus one op -> 0x0000.
